// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with a memory request/acknowledge handshake.
// Sequences IF/ID/EXE/MEM/WB and drives the datapath control encodings,
// flags illegal encodings and counts retired instructions.
module mc_ctrl_hs #(
  parameter int USE_ACK  = 0,
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             pcwr,
  output logic             irwr,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ExtOp,
  output logic [1:0]       npc_sel,
  output logic             write_30,
  output logic             islb,
  output logic             issb,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLT, I_JR,
    I_ORI, I_ADDI, I_LUI,
    I_LW, I_LB, I_SW, I_SB,
    I_BEQ, I_J, I_JAL, I_BAD
  } instr_t;

  state_t cur;
  state_t nxt;
  instr_t ins;
  logic   rst_q;
  logic   blank;
  logic   ack;
  logic   retire;
  logic   is_ld;
  logic   is_st;

  // Outputs are held at zero while rst is high and for the cycle after it.
  assign blank   = rst | rst_q;
  assign mem_req = !blank && ((cur == S_IF) || (cur == S_MEM));
  assign state   = blank ? S_IF : cur;
  assign is_ld   = (ins == I_LW) || (ins == I_LB);
  assign is_st   = (ins == I_SW) || (ins == I_SB);

  generate
    if (USE_ACK != 0) begin : g_ext_ack
      // External acknowledge, only honoured while an access is in progress.
      assign ack = mem_req & mem_ack;
    end else begin : g_int_ack
      localparam logic [3:0] WAIT_LIM = 4'(MEM_WAIT);
      logic [3:0] wcnt;
      logic       unused_ack;
      assign unused_ack = mem_ack;
      assign ack        = mem_req && (wcnt == WAIT_LIM);
      // Wait-state counter: counts cycles of the current access, clears on ack.
      always_ff @(posedge clk) begin
        if (rst) begin
          wcnt <= '0;
        end else if (mem_req) begin
          wcnt <= ack ? '0 : wcnt + 4'd1;
        end
      end
    end
  endgenerate

  // Instruction decode from the IR opcode/funct fields.
  always_comb begin
    ins = I_BAD;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: ins = I_ADDU;
          6'b100011: ins = I_SUBU;
          6'b101010: ins = I_SLT;
          6'b001000: ins = I_JR;
          default:   ins = I_BAD;
        endcase
      end
      6'b001101: ins = I_ORI;
      6'b001000: ins = I_ADDI;
      6'b001111: ins = I_LUI;
      6'b100011: ins = I_LW;
      6'b100000: ins = I_LB;
      6'b101011: ins = I_SW;
      6'b101000: ins = I_SB;
      6'b000100: ins = I_BEQ;
      6'b000010: ins = I_J;
      6'b000011: ins = I_JAL;
      default:   ins = I_BAD;
    endcase
  end

  // Control outputs, next state and retirement from state and IR.
  always_comb begin
    pcwr     = 1'b0;
    irwr     = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    RegDst   = 2'b00;
    MemToReg = 2'b00;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    ExtOp    = 2'b00;
    npc_sel  = 2'b00;
    write_30 = 1'b0;
    islb     = 1'b0;
    issb     = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;
    nxt      = cur;
    if (!blank) begin
      case (cur)
        S_IF: begin
          if (ack) begin
            irwr = 1'b1;
            pcwr = 1'b1;
            nxt  = S_ID;
          end
        end
        S_ID: begin
          case (ins)
            I_J: begin
              pcwr    = 1'b1;
              npc_sel = 2'b10;
              retire  = 1'b1;
              nxt     = S_IF;
            end
            I_JAL: begin
              pcwr     = 1'b1;
              npc_sel  = 2'b10;
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              MemToReg = 2'b10;
              retire   = 1'b1;
              nxt      = S_IF;
            end
            I_JR: begin
              pcwr    = 1'b1;
              npc_sel = 2'b11;
              retire  = 1'b1;
              nxt     = S_IF;
            end
            I_BAD: begin
              illegal = 1'b1;
              nxt     = S_IF;
            end
            default: nxt = S_EXE;
          endcase
        end
        S_EXE: begin
          nxt = S_WB;
          case (ins)
            I_SUBU: ALUOp = 2'b01;
            I_SLT:  ALUOp = 2'b11;
            I_ORI: begin
              ALUSrc = 1'b1;
              ALUOp  = 2'b10;
            end
            I_LUI: begin
              ALUSrc = 1'b1;
              ExtOp  = 2'b10;
              ALUOp  = 2'b10;
            end
            I_ADDI: begin
              ALUSrc   = 1'b1;
              ExtOp    = 2'b01;
              write_30 = 1'b1;
            end
            I_LW, I_LB, I_SW, I_SB: begin
              ALUSrc = 1'b1;
              ExtOp  = 2'b01;
              nxt    = S_MEM;
            end
            I_BEQ: begin
              ALUOp   = 2'b01;
              npc_sel = 2'b01;
              pcwr    = zero;
              retire  = 1'b1;
              nxt     = S_IF;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          // Address path kept identical to EXE so the address is stable.
          ALUSrc = 1'b1;
          ExtOp  = 2'b01;
          islb   = (ins == I_LB);
          issb   = (ins == I_SB);
          if (ack) begin
            if (is_st) begin
              MemWrite = 1'b1;
              retire   = 1'b1;
              nxt      = S_IF;
            end else begin
              nxt = S_WB;
            end
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          if ((ins == I_ADDU) || (ins == I_SUBU) || (ins == I_SLT)) begin
            RegDst = 2'b01;
          end
          if (is_ld) begin
            MemToReg = 2'b01;
          end
          write_30 = (ins == I_ADDI);
          islb     = (ins == I_LB);
          retire   = 1'b1;
          nxt      = S_IF;
        end
        default: nxt = S_IF;
      endcase
    end
  end

  // State register, reset-blank flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_IF;
      rst_q   <= 1'b1;
      instret <= '0;
    end else begin
      rst_q <= 1'b0;
      cur   <= nxt;
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

endmodule
